// File: rtl/branch_resolve_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl_pkg
// Description : Branch kinds, funct3 compare codes and controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] c_beq  = 3'b000;
    localparam logic [2:0] c_bne  = 3'b001;
    localparam logic [2:0] c_blt  = 3'b100;
    localparam logic [2:0] c_bge  = 3'b101;
    localparam logic [2:0] c_bltu = 3'b110;
    localparam logic [2:0] c_bgeu = 3'b111;

    localparam logic [1:0] c_bk_br   = 2'd0;
    localparam logic [1:0] c_bk_jal  = 2'd1;
    localparam logic [1:0] c_bk_jalr = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OPS = 2'd1,
        ST_EVAL     = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    // JALR takes its base from rs1 and drops bit 0; everything else is PC-relative.
    function automatic logic [31:0] calc_target(input logic [1:0]  kind,
                                                input logic [31:0] pc,
                                                input logic [31:0] imm,
                                                input logic [31:0] rs1);
        if (kind == c_bk_jalr)
            return (rs1 + imm) & ~32'h1;
        return pc + imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_ctrl_branch_comp.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl_branch_comp
// Description : RV32 conditional-branch comparator (BranchComp).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl_branch_comp
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_op)
            c_beq:   o_taken = (i_rs1 == i_rs2);
            c_bne:   o_taken = (i_rs1 != i_rs2);
            c_blt:   o_taken = ($signed(i_rs1) <  $signed(i_rs2));
            c_bge:   o_taken = ($signed(i_rs1) >= $signed(i_rs2));
            c_bltu:  o_taken = (i_rs1 <  i_rs2);
            c_bgeu:  o_taken = (i_rs1 >= i_rs2);
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : Execute-stage branch/jump resolution with redirect, flush and
//               perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_branch_op,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic             opnd_valid,
    input  logic [31:0]      opnd_rs1,
    input  logic [31:0]      opnd_rs2,
    input  logic             kill,
    output logic             resolve_valid,
    output logic             resolve_taken,
    output logic [31:0]      link_value,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             misalign_exc,
    output logic             flush,
    output logic [CNT_W-1:0] cnt_resolved,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam int                c_fcnt_w   = $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_fcnt_w-1:0] c_fcnt_load = c_fcnt_w'(FLUSH_CYCLES);
    localparam logic [c_fcnt_w-1:0] c_fcnt_one  = c_fcnt_w'(1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [1:0]          r_kind;
    logic [2:0]          r_op;
    logic [31:0]         r_pc;
    logic [31:0]         r_imm;
    logic [31:0]         r_rs1;
    logic [31:0]         r_rs2;
    logic [c_fcnt_w-1:0] r_flush_cnt;

    logic                w_cmp_taken;
    logic                w_taken;
    logic [31:0]         w_target;
    logic                w_misalign;
    logic                w_fire;

    logic                r_resolve_valid;
    logic                r_resolve_taken;
    logic                r_redirect_valid;
    logic                r_misalign_exc;
    logic [31:0]         r_link_value;
    logic [31:0]         r_redirect_pc;
    logic [CNT_W-1:0]    r_cnt_resolved;
    logic [CNT_W-1:0]    r_cnt_taken;

    branch_resolve_ctrl_branch_comp u_branch_comp (
        .i_op    (r_op),
        .i_rs1   (r_rs1),
        .i_rs2   (r_rs2),
        .o_taken (w_cmp_taken)
    );

    assign w_taken    = (r_kind == c_bk_br) ? w_cmp_taken : 1'b1;
    assign w_target   = calc_target(r_kind, r_pc, r_imm, r_rs1);
    assign w_misalign = w_taken && w_target[1];
    assign w_fire     = (r_state == ST_EVAL) && !kill;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (in_valid) w_state_nxt = opnd_valid ? ST_EVAL : ST_WAIT_OPS;
            ST_WAIT_OPS: if (opnd_valid) w_state_nxt = ST_EVAL;
            ST_EVAL:     w_state_nxt = (w_taken && !w_misalign) ? ST_FLUSH : ST_IDLE;
            ST_FLUSH:    if (r_flush_cnt == c_fcnt_one) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
        if (kill)
            w_state_nxt = ST_IDLE;
    end

    // Instruction fields and operands; state transitions decide whether they are used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kind <= c_bk_br;
            r_op   <= c_beq;
            r_pc   <= 32'd0;
            r_imm  <= 32'd0;
            r_rs1  <= 32'd0;
            r_rs2  <= 32'd0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_kind <= in_kind;
                r_op   <= in_branch_op;
                r_pc   <= in_pc;
                r_imm  <= in_imm;
            end
            if ((r_state == ST_IDLE && in_valid && opnd_valid) ||
                (r_state == ST_WAIT_OPS && opnd_valid)) begin
                r_rs1 <= opnd_rs1;
                r_rs2 <= opnd_rs2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_flush_cnt <= '0;
        else if (w_state_nxt == ST_FLUSH && r_state != ST_FLUSH)
            r_flush_cnt <= c_fcnt_load;
        else if (r_state == ST_FLUSH)
            r_flush_cnt <= r_flush_cnt - c_fcnt_one;
    end

    // A misaligned target raises the exception instead of resolving, but still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resolve_valid  <= 1'b0;
            r_resolve_taken  <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_misalign_exc   <= 1'b0;
            r_link_value     <= 32'd0;
            r_redirect_pc    <= 32'd0;
            r_cnt_resolved   <= '0;
            r_cnt_taken      <= '0;
        end else begin
            r_resolve_valid  <= w_fire && !w_misalign;
            r_resolve_taken  <= w_fire && w_taken && !w_misalign;
            r_redirect_valid <= w_fire && w_taken && !w_misalign;
            r_misalign_exc   <= w_fire && w_misalign;
            if (w_fire) begin
                r_link_value   <= r_pc + 32'd4;
                r_redirect_pc  <= w_target;
                r_cnt_resolved <= r_cnt_resolved + CNT_W'(1);
                if (w_taken)
                    r_cnt_taken <= r_cnt_taken + CNT_W'(1);
            end
        end
    end

    assign in_ready       = (r_state == ST_IDLE);
    assign flush          = (r_state == ST_FLUSH);
    assign resolve_valid  = r_resolve_valid;
    assign resolve_taken  = r_resolve_taken;
    assign redirect_valid = r_redirect_valid;
    assign misalign_exc   = r_misalign_exc;
    assign link_value     = r_link_value;
    assign redirect_pc    = r_redirect_pc;
    assign cnt_resolved   = r_cnt_resolved;
    assign cnt_taken      = r_cnt_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_ctrl
// Description : Directed and random stimulus against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;

    localparam logic [1:0] K_BR = 2'd0, K_JAL = 2'd1, K_JALR = 2'd2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_kind;
    logic [2:0]       in_branch_op;
    logic [31:0]      in_pc;
    logic [31:0]      in_imm;
    logic             opnd_valid;
    logic [31:0]      opnd_rs1;
    logic [31:0]      opnd_rs2;
    logic             kill;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [31:0]      link_value;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             misalign_exc;
    logic             flush;
    logic [CNT_W-1:0] cnt_resolved;
    logic [CNT_W-1:0] cnt_taken;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] m_res = '0;
    logic [CNT_W-1:0] m_tak = '0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_branch_op(in_branch_op), .in_pc(in_pc), .in_imm(in_imm),
        .opnd_valid(opnd_valid), .opnd_rs1(opnd_rs1), .opnd_rs2(opnd_rs2), .kill(kill),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .link_value(link_value),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_exc(misalign_exc),
        .flush(flush), .cnt_resolved(cnt_resolved), .cnt_taken(cnt_taken)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken(input logic [1:0] kind, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
        if (kind != K_BR) return 1'b1;
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_opnds(input logic v, input logic [31:0] a, input logic [31:0] b);
        opnd_valid = v;
        opnd_rs1   = v ? a : $urandom;
        opnd_rs2   = v ? b : $urandom;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ":rv"},  32'(resolve_valid),  32'd0);
        check({tag, ":rdv"}, 32'(redirect_valid), 32'd0);
        check({tag, ":mis"}, 32'(misalign_exc),   32'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, ":cnt_res"}, 32'(cnt_resolved), 32'(m_res));
        check({tag, ":cnt_tak"}, 32'(cnt_taken),    32'(m_tak));
    endtask

    // Full transaction: accept, optional operand wait, evaluation, flush drain.
    task automatic run_op(input string tag, input logic [1:0] kind, input logic [2:0] op,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2, input int waitc);
        logic tk, mis, rd;
        logic [31:0] tgt;
        tk  = model_taken(kind, op, rs1, rs2);
        tgt = (kind == K_JALR) ? ((rs1 + imm) & ~32'h1) : (pc + imm);
        mis = tk && tgt[1];
        rd  = tk && !mis;
        check({tag, ":rdy_in"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_kind = kind; in_branch_op = op; in_pc = pc; in_imm = imm;
        drive_opnds(waitc == 0, rs1, rs2);
        step();
        in_valid = 1'b0; in_pc = $urandom; in_imm = $urandom;
        for (int w = 0; w < waitc; w++) begin
            check({tag, ":rdy_wait"}, 32'(in_ready), 32'd0);
            check_quiet({tag, ":wait"});
            drive_opnds(w == waitc - 1, rs1, rs2);
            step();
        end
        check({tag, ":rdy_eval"}, 32'(in_ready), 32'd0);
        check_quiet({tag, ":eval"});
        drive_opnds(1'b0, rs1, rs2);
        step();
        if (!mis) m_res = m_res + 1'b1;
        else      m_res = m_res + 1'b1;
        if (tk)   m_tak = m_tak + 1'b1;
        check({tag, ":rv"},    32'(resolve_valid),  32'(!mis));
        check({tag, ":rt"},    32'(resolve_taken),  32'(rd));
        check({tag, ":rdv"},   32'(redirect_valid), 32'(rd));
        check({tag, ":mis"},   32'(misalign_exc),   32'(mis));
        check({tag, ":flush"}, 32'(flush),          32'(rd));
        check({tag, ":rdy"},   32'(in_ready),       32'(!rd));
        if (!mis) check({tag, ":link"}, link_value, pc + 32'd4);
        if (rd)   check({tag, ":tgt"},  redirect_pc, tgt);
        if (rd) begin
            for (int i = 1; i < FLUSH_CYCLES; i++) begin
                step();
                check({tag, ":flush_hold"}, 32'(flush), 32'd1);
                check({tag, ":rdy_flush"},  32'(in_ready), 32'd0);
                check_quiet({tag, ":flush"});
            end
            step();
            check({tag, ":flush_end"}, 32'(flush), 32'd0);
            check({tag, ":rdy_end"},   32'(in_ready), 32'd1);
        end
        check_counters(tag);
    endtask

    // Abort an op with kill in WAIT_OPS (0), EVAL (1) or FLUSH (2).
    task automatic kill_op(input string tag, input int phase);
        in_valid = 1'b1; in_kind = K_BR; in_branch_op = 3'b000;
        in_pc = 32'h400; in_imm = 32'h40;
        drive_opnds(phase != 0, 32'd7, 32'd7);
        step();
        in_valid = 1'b0;
        drive_opnds(1'b0, 0, 0);
        if (phase == 2) begin
            step();
            m_res = m_res + 1'b1;
            m_tak = m_tak + 1'b1;
            check({tag, ":flush_pre"}, 32'(flush), 32'd1);
        end
        kill = 1'b1;
        step();
        kill = 1'b0;
        check({tag, ":rdy"},   32'(in_ready), 32'd1);
        check({tag, ":flush"}, 32'(flush),    32'd0);
        check_quiet(tag);
        step();
        check_quiet({tag, ":after"});
        check_counters(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_kind = '0; in_branch_op = '0;
        in_pc = '0; in_imm = '0; kill = 1'b0;
        drive_opnds(1'b0, 0, 0);
        repeat (3) step();
        reset = 1'b0;
        check("reset:rdy", 32'(in_ready), 32'd1);
        check("reset:flush", 32'(flush), 32'd0);
        check("reset:rt", 32'(resolve_taken), 32'd0);
        check("reset:link", link_value, 32'd0);
        check("reset:rpc", redirect_pc, 32'd0);
        check_quiet("reset");
        check_counters("reset");

        run_op("beq_eq",   K_BR,   3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0);
        run_op("blt_neg",  K_BR,   3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("bltu_neg", K_BR,   3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("jalr_203", K_JALR, 3'b000, 32'h300, 32'h0, 32'h203, 32'd0, 0);
        run_op("jalr_301", K_JALR, 3'b000, 32'h300, 32'h200, 32'h101, 32'd0, 0);
        run_op("jal_mis",  K_JAL,  3'b000, 32'h0, 32'h6, 32'd0, 32'd0, 0);
        run_op("bne_wait", K_BR,   3'b001, 32'h500, 32'hFFFF_FFF0, 32'd3, 32'd4, 4);
        run_op("op010",    K_BR,   3'b010, 32'h600, 32'h8, 32'd1, 32'd2, 1);
        run_op("bgeu",     K_BR,   3'b111, 32'h700, 32'h0C, 32'd9, 32'd9, 2);

        kill_op("kill_wait",  0);
        kill_op("kill_eval",  1);
        kill_op("kill_flush", 2);

        in_valid = 1'b1; kill = 1'b1; in_kind = K_JAL; in_pc = 32'h800; in_imm = 32'h10;
        drive_opnds(1'b1, 0, 0);
        step();
        in_valid = 1'b0; kill = 1'b0;
        drive_opnds(1'b0, 0, 0);
        check("kill_idle:rdy", 32'(in_ready), 32'd1);
        step();
        check_quiet("kill_idle");
        check_counters("kill_idle");

        // Reset while flushing.
        in_valid = 1'b1; in_kind = K_JAL; in_pc = 32'h900; in_imm = 32'h100;
        drive_opnds(1'b1, 0, 0);
        step();
        in_valid = 1'b0;
        drive_opnds(1'b0, 0, 0);
        step();
        check("rst_flush:flush_pre", 32'(flush), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_res = '0; m_tak = '0;
        check("rst_flush:flush", 32'(flush), 32'd0);
        check("rst_flush:link", link_value, 32'd0);
        check("rst_flush:rpc", redirect_pc, 32'd0);
        check("rst_flush:rt", 32'(resolve_taken), 32'd0);
        check_quiet("rst_flush");
        check_counters("rst_flush");

        for (int i = 0; i < 16; i++)
            run_op("wrap", K_BR, 3'b001, 32'h40, 32'h8, 32'd2, 32'd2, 0);
        check("wrap:cnt_res_zero", 32'(cnt_resolved), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] r, a, b, pc, imm;
            logic [1:0]  kind;
            r    = $urandom;
            kind = 2'($urandom_range(0, 2));
            pc   = $urandom & ~32'h3;
            imm  = {{22{r[9]}}, r[9:1], 1'b0};
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op("rand", kind, 3'($urandom_range(0, 7)), pc, imm, a, b,
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
